reg_bus_slave: RTL and testbench
================================

// Module: reg_bus_slave
//
// PURPOSE
//   Slave end of the my_if register bus; binds to the my_if slave modport.
//   Holds a flop-based register file addressed by an 8-bit address.
//   Accepts single-cycle writes and returns registered read data.
//   Sits behind the bus master, which drives write/address/data_in on the clk falling edge.
//
// PARAMETERS
//   ADDR_W    8         address width; register file depth is 2**ADDR_W
//   DATA_W    16        data width of data_in, data_out and each register
//   ID_VALUE  16'h5A01  constant returned by the ID register at address 8'hFF
//
// PORTS
//   clk       input   1       bus clock; all state updates on the rising edge
//   rst_n     input   1       asynchronous, active-low reset
//   write     input   1       1 = write data_in to address this cycle; 0 = read
//   data_in   input   DATA_W  write data
//   address   input   ADDR_W  register select
//   data_out  output  DATA_W  registered read data
//
// BEHAVIOUR
//   - Reset: asserting rst_n low asynchronously forces the following state.
//     - every register is 0
//     - write counter (WCNT) is 0
//     - data_out is 0
//     - lock bit is 0
//   - Reset released mid-operation: the first rising edge with rst_n=1 is an ordinary cycle.
//   - Inputs are sampled on the rising edge of clk. The master drives on the falling edge, so
//     inputs are stable half a cycle before sampling.
//   - Address map:
//     - 8'h00-8'hFD: general read/write registers
//     - 8'hFE: WCNT, read-only; counts accepted writes, DATA_W wide, wraps 16'hFFFF -> 16'h0000
//     - 8'hFF: ID, read-only; always returns ID_VALUE
//   - Write cycle (write=1):
//     - A writable address is updated with data_in at the edge, and WCNT increments.
//     - A write to 8'hFE or 8'hFF is dropped: no state change and no WCNT increment.
//   - Read latency is 1 cycle.
//     - data_out, registered at edge N, shows the contents of the register at the address
//       sampled at edge N.
//     - On a write cycle, data_out returns the value after that write (write-first). For a
//       dropped write it returns the unchanged contents.
//     - A read of 8'hFE returns WCNT including any increment made at the same edge.
//   - data_out updates every cycle; there is no hold or enable and no handshake.
//   - A write is always accepted in one cycle and there is no backpressure.
//   - Back-to-back writes to the same address: the last write wins, and each one counts in WCNT.
//
// CONFIGURATION
//   REG_BUS_LOCK_EN
//     Defined:
//       - Address 8'hFD is the LOCK register. Only bit 0 is stored; bits 15:1 read 0.
//       - While LOCK[0]=1, writes to 8'h00-8'hFC are dropped: no update and no WCNT increment.
//       - Writes to 8'hFD itself are always accepted and counted, so software can unlock.
//     Not defined:
//       - 8'hFD is an ordinary read/write register.
//       - No write is ever blocked.
//
// TESTING
//   1. Reset with rst_n=0, then read 8'h00, 8'h10 and 8'hFE -> data_out=16'h0000 each.
//      Read 8'hFF -> 16'h5A01.
//   2. Write 16'h0001, 16'h0002, 16'h0003 to 8'h00, 8'h01, 8'h02, then read them back ->
//      16'h0001, 16'h0002, 16'h0003 at 1-cycle latency, and 8'hFE reads 16'h0003.
//   3. Write 16'hBEEF to 8'hFF, then 16'h1234 to 8'hFE -> 8'hFF still reads 16'h5A01,
//      and WCNT is unchanged.
//   4. Preload WCNT to 16'hFFFF with 65535 writes, then do 1 more write -> 8'hFE reads 16'h0000.
//   5. Write 16'hCAFE to 8'h20, then pulse rst_n low between edges -> data_out drops to 0
//      immediately, and 8'h20 reads 16'h0000 after release.
//   6. (REG_BUS_LOCK_EN) Write 1 to 8'hFD, then 16'h7777 to 8'h05 -> 8'h05 reads 0.
//      Write 0 to 8'hFD, then 16'h7777 to 8'h05 -> 8'h05 reads 16'h7777.

Source files
------------

// File: rtl/reg_bus_slave_if.sv
// my_if register bus: master drives write/address/data_in, slave returns data_out.
interface my_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              write;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_out;

  modport master (output write, output data_in, output address, input data_out);
  modport slave  (input write, input data_in, input address, output data_out);
endinterface

// File: rtl/reg_bus_slave.sv
// Flop-based register file slave on the my_if bus with a write counter and an ID register.
// Optional REG_BUS_LOCK_EN turns address 2**ADDR_W-3 into a write-lock register.
module reg_bus_slave #(
  parameter int               ADDR_W   = 8,
  parameter int               DATA_W   = 16,
  parameter logic [DATA_W-1:0] ID_VALUE = 16'h5A01
) (
  input  logic clk,
  input  logic rst_n,
  my_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] WCNT_ADDR = ADDR_W'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] ID_ADDR   = ADDR_W'(DEPTH - 1);
`ifdef REG_BUS_LOCK_EN
  localparam logic [ADDR_W-1:0] LOCK_ADDR = ADDR_W'(DEPTH - 3);
  logic lock_q;
  logic lock_d;
`endif

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] wcnt_q;
  logic [DATA_W-1:0] wcnt_d;
  logic [DATA_W-1:0] data_out_q;
  logic [DATA_W-1:0] data_out_d;
  logic              wr_ok_s;
  logic              store_s;

  // Write acceptance, counter/lock next state and write-first read mux.
  always_comb begin
    wr_ok_s    = 1'b0;
    store_s    = 1'b0;
    wcnt_d     = wcnt_q;
    data_out_d = regs_q[bus.address];
`ifdef REG_BUS_LOCK_EN
    lock_d     = lock_q;
`endif

    if (bus.write && (bus.address < WCNT_ADDR)) begin
`ifdef REG_BUS_LOCK_EN
      if (!lock_q || (bus.address == LOCK_ADDR)) begin
        wr_ok_s = 1'b1;
      end else begin
        wr_ok_s = 1'b0;
      end
`else
      wr_ok_s = 1'b1;
`endif
    end else begin
      wr_ok_s = 1'b0;
    end

`ifdef REG_BUS_LOCK_EN
    if (wr_ok_s && (bus.address == LOCK_ADDR)) begin
      lock_d  = bus.data_in[0];
      store_s = 1'b0;
    end else begin
      lock_d  = lock_q;
      store_s = wr_ok_s;
    end
`else
    store_s = wr_ok_s;
`endif

    if (wr_ok_s) begin
      wcnt_d = wcnt_q + DATA_W'(1);
    end else begin
      wcnt_d = wcnt_q;
    end

    if (bus.address == ID_ADDR) begin
      data_out_d = ID_VALUE;
    end else if (bus.address == WCNT_ADDR) begin
      data_out_d = wcnt_d;
`ifdef REG_BUS_LOCK_EN
    end else if (bus.address == LOCK_ADDR) begin
      data_out_d = {{(DATA_W-1){1'b0}}, lock_d};
`endif
    end else if (store_s) begin
      data_out_d = bus.data_in;
    end else begin
      data_out_d = regs_q[bus.address];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      wcnt_q     <= {DATA_W{1'b0}};
      data_out_q <= {DATA_W{1'b0}};
`ifdef REG_BUS_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      if (store_s) begin
        regs_q[bus.address] <= bus.data_in;
      end
      wcnt_q     <= wcnt_d;
      data_out_q <= data_out_d;
`ifdef REG_BUS_LOCK_EN
      lock_q     <= lock_d;
`endif
    end
  end

  assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_reg_bus_slave.sv
// Directed plus randomized bench for reg_bus_slave against an address-map level model.
module tb_reg_bus_slave;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  my_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  reg_bus_slave #(.ADDR_W(8), .DATA_W(16), .ID_VALUE(16'h5A01)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register contents, accepted-write count, lock bit.
  logic [15:0] m_mem [256];
  int          m_wcnt;
  bit          m_lock;

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
    m_wcnt = 0;
    m_lock = 1'b0;
  endfunction

  function automatic logic [15:0] model_step(input logic w, input logic [7:0] a, input logic [15:0] d);
    bit accept;
    bit lock_feature;
`ifdef REG_BUS_LOCK_EN
    lock_feature = 1'b1;
`else
    lock_feature = 1'b0;
`endif
    if (w) begin
      accept = (a <= 8'hFD);
      if (lock_feature && m_lock && a != 8'hFD) accept = 1'b0;
      if (accept) begin
        if (lock_feature && a == 8'hFD) m_lock = d[0];
        else m_mem[a] = d;
        m_wcnt = (m_wcnt + 1) % 65536;
      end
    end
    if (a == 8'hFF) return 16'h5A01;
    if (a == 8'hFE) return 16'(m_wcnt);
    if (lock_feature && a == 8'hFD) return {15'h0000, m_lock};
    return m_mem[a];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic w, input logic [7:0] a, input logic [15:0] d, input string tag);
    logic [15:0] exp;
    @(negedge clk);
    bus.write   = w;
    bus.address = a;
    bus.data_in = d;
    exp = model_step(w, a, d);
    @(posedge clk);
    #1;
    check(tag, bus.data_out, exp);
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check(tag, bus.data_out, 16'h0000);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] ra;
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.write = 1'b0;
    bus.address = 8'h00;
    bus.data_in = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset_dout", bus.data_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: reset contents and ID
    cycle(1'b0, 8'h00, 16'h0000, "rd00_reset");
    cycle(1'b0, 8'h10, 16'h0000, "rd10_reset");
    cycle(1'b0, 8'hFE, 16'h0000, "wcnt_reset");
    cycle(1'b0, 8'hFF, 16'h0000, "id_read");
    check("id_const", bus.data_out, 16'h5A01);

    // 2: basic writes and readback
    cycle(1'b1, 8'h00, 16'h0001, "wr00");
    cycle(1'b1, 8'h01, 16'h0002, "wr01");
    cycle(1'b1, 8'h02, 16'h0003, "wr02");
    cycle(1'b0, 8'h00, 16'h0000, "rd00");
    cycle(1'b0, 8'h01, 16'h0000, "rd01");
    cycle(1'b0, 8'h02, 16'h0000, "rd02");
    check("rd02_const", bus.data_out, 16'h0003);
    cycle(1'b0, 8'hFE, 16'h0000, "wcnt3");
    check("wcnt3_const", bus.data_out, 16'h0003);

    // 3: read-only addresses drop writes
    cycle(1'b1, 8'hFF, 16'hBEEF, "wrFF_drop");
    cycle(1'b1, 8'hFE, 16'h1234, "wrFE_drop");
    cycle(1'b0, 8'hFF, 16'h0000, "id_after");
    cycle(1'b0, 8'hFE, 16'h0000, "wcnt_after");
    check("wcnt_after_const", bus.data_out, 16'h0003);

    // Back-to-back same address: last wins, both count
    cycle(1'b1, 8'h30, 16'h1111, "b2b_a");
    cycle(1'b1, 8'h30, 16'h2222, "b2b_b");
    cycle(1'b0, 8'h30, 16'h0000, "b2b_rd");
    cycle(1'b0, 8'hFE, 16'h0000, "b2b_wcnt");

    // Randomized traffic with address collisions and read-only/lock addresses
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) ra = 8'hFC + 8'($urandom_range(0, 3));
      else ra = 8'($urandom_range(0, 15));
      cycle(1'($urandom_range(0, 1)), ra, 16'($urandom), "random");
    end

    // 4: WCNT wrap
    pulse_reset("reset_pre_wrap");
    for (int i = 0; i < 65535; i++) begin
      cycle(1'b1, 8'($urandom_range(0, 252)), 16'($urandom), "preload");
    end
    cycle(1'b0, 8'hFE, 16'h0000, "wcnt_ffff");
    check("wcnt_ffff_const", bus.data_out, 16'hFFFF);
    cycle(1'b1, 8'h07, 16'h00AA, "wrap_write");
    cycle(1'b0, 8'hFE, 16'h0000, "wcnt_wrap");
    check("wcnt_wrap_const", bus.data_out, 16'h0000);

    // 5: asynchronous reset mid-operation
    cycle(1'b1, 8'h20, 16'hCAFE, "wr20");
    check("wr20_const", bus.data_out, 16'hCAFE);
    pulse_reset("async_reset");
    cycle(1'b0, 8'h20, 16'h0000, "rd20_reset");
    check("rd20_reset_const", bus.data_out, 16'h0000);

`ifdef REG_BUS_LOCK_EN
    // 6: lock register blocks general writes
    cycle(1'b1, 8'hFD, 16'h0001, "lock_set");
    cycle(1'b1, 8'h05, 16'h7777, "locked_wr");
    cycle(1'b0, 8'h05, 16'h0000, "locked_rd");
    check("locked_rd_const", bus.data_out, 16'h0000);
    cycle(1'b1, 8'hFD, 16'hFFFE, "unlock");
    cycle(1'b1, 8'h05, 16'h7777, "unlocked_wr");
    cycle(1'b0, 8'h05, 16'h0000, "unlocked_rd");
    check("unlocked_rd_const", bus.data_out, 16'h7777);
`else
    cycle(1'b1, 8'hFD, 16'hA5A5, "wrFD_plain");
    cycle(1'b0, 8'hFD, 16'h0000, "rdFD_plain");
    check("rdFD_plain_const", bus.data_out, 16'hA5A5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
